tdc_meas_ctrl: RTL and testbench

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_ctrl_pkg.sv | 20 ++
 rtl/tdc_ctrl_accum.sv | 57 +++++
 rtl/tdc_meas_ctrl.sv | 116 +++++++++++
 tb/tb_tdc_meas_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_ctrl_pkg.sv
// Shared constants for the TDC measurement controller: default widths and
// the FSM state encoding used by tdc_meas_ctrl.
package tdc_ctrl_pkg;

  localparam int HW_W_DEF     = 7;
  localparam int NS_LOG2_DEF  = 4;
  localparam int SYNC_LAT_DEF = 2;
  localparam int GAP_W_DEF    = 4;

  typedef logic [2:0] tdc_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LAUNCH  = 3'd1;
  localparam logic [2:0] ST_GAP     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SYNC    = 3'd4;
  localparam logic [2:0] ST_ACCUM   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

endpackage

// File: rtl/tdc_ctrl_accum.sv
// Running sum / min / max / sample count for one measurement. Exposes the
// post-update values so the controller can capture final results in ACCUM.
module tdc_ctrl_accum
  import tdc_ctrl_pkg::*;
#(
  parameter int HW_W    = HW_W_DEF,
  parameter int NS_LOG2 = NS_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic [HW_W-1:0]         sample,
  output logic [HW_W+NS_LOG2-1:0] sum_nxt,
  output logic [HW_W-1:0]         min_nxt,
  output logic [HW_W-1:0]         max_nxt,
  output logic                    full_nxt
);

  localparam int SUM_W = HW_W + NS_LOG2;
  localparam int CNT_W = NS_LOG2 + 1;

  logic [SUM_W-1:0] sum_q;
  logic [HW_W-1:0]  min_q;
  logic [HW_W-1:0]  max_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    sum_nxt  = sum_q + SUM_W'(sample);
    min_nxt  = (sample < min_q) ? sample : min_q;
    max_nxt  = (sample > max_q) ? sample : max_q;
    cnt_nxt  = cnt_q + CNT_W'(1);
    full_nxt = cnt_nxt[NS_LOG2];
  end

  // Min starts at all-ones so the first sample always replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
    end else if (upd) begin
      sum_q <= sum_nxt;
      min_q <= min_nxt;
      max_q <= max_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for a TDC: issues launch/capture pulse pairs, collects
// 2^NS_LOG2 Hamming-weight samples and presents sum/min/max with a handshake.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int HW_W     = HW_W_DEF,
  parameter int NS_LOG2  = NS_LOG2_DEF,
  parameter int SYNC_LAT = SYNC_LAT_DEF,
  parameter int GAP_W    = GAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [GAP_W-1:0]        cfg_gap,
  output logic                    launch,
  output logic                    capture,
  input  logic [HW_W-1:0]         hw_in,
  output logic                    busy,
  output logic [HW_W+NS_LOG2-1:0] res_sum,
  output logic [HW_W-1:0]         res_min,
  output logic [HW_W-1:0]         res_max,
  output logic                    res_valid,
  input  logic                    res_ready
);

  localparam int SUM_W  = HW_W + NS_LOG2;
  localparam int SYNC_W = (SYNC_LAT < 1) ? 1 : $clog2(SYNC_LAT + 1);
  localparam logic [SYNC_W-1:0] SYNC_INIT = SYNC_W'(SYNC_LAT);

  tdc_state_t        state_q;
  tdc_state_t        state_d;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [SUM_W-1:0]  res_sum_q;
  logic [HW_W-1:0]   res_min_q;
  logic [HW_W-1:0]   res_max_q;

  logic              acc_clr;
  logic              acc_upd;
  logic              acc_full;
  logic [SUM_W-1:0]  acc_sum;
  logic [HW_W-1:0]   acc_min;
  logic [HW_W-1:0]   acc_max;
  logic              ld_res;

  assign acc_clr = (state_q == ST_IDLE) && start;
  assign acc_upd = (state_q == ST_ACCUM) && !abort;
  assign ld_res  = acc_upd && acc_full;

  tdc_ctrl_accum #(
    .HW_W    (HW_W),
    .NS_LOG2 (NS_LOG2)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .upd      (acc_upd),
    .sample   (hw_in),
    .sum_nxt  (acc_sum),
    .min_nxt  (acc_min),
    .max_nxt  (acc_max),
    .full_nxt (acc_full)
  );

  // SYNC covers the cycle the TDC registers the capture plus SYNC_LAT
  // synchroniser cycles, giving a sample period of 4 + gap + SYNC_LAT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = (gap_q != '0) ? ST_GAP : ST_CAPTURE;
      ST_GAP:     if (gap_cnt == '0) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SYNC;
      ST_SYNC:    if (sync_cnt == '0) state_d = ST_ACCUM;
      ST_ACCUM:   state_d = acc_full ? ST_DONE : ST_LAUNCH;
      ST_DONE:    if (res_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      gap_cnt   <= '0;
      sync_cnt  <= '0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc_clr) gap_q <= cfg_gap;
      if (state_q == ST_LAUNCH) gap_cnt <= gap_q - GAP_W'(1);
      else if ((state_q == ST_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);
      if (state_q == ST_CAPTURE) sync_cnt <= SYNC_INIT;
      else if ((state_q == ST_SYNC) && (sync_cnt != '0)) sync_cnt <= sync_cnt - SYNC_W'(1);
      if (ld_res) begin
        res_sum_q <= acc_sum;
        res_min_q <= acc_min;
        res_max_q <= acc_max;
      end
    end
  end

  assign launch    = (state_q == ST_LAUNCH);
  assign capture   = (state_q == ST_CAPTURE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_sum   = res_sum_q;
  assign res_min   = res_min_q;
  assign res_max   = res_max_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: stimulus pushes expected results, a
// forked monitor checks pulse timing and pops/compares on every handshake.
module tb_tdc_meas_ctrl;

  localparam int HW_W    = 7;
  localparam int NS_LOG2 = 4;
  localparam int GAP_W   = 4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    abort;
  logic [GAP_W-1:0]        cfg_gap;
  logic                    launch;
  logic                    capture;
  logic [HW_W-1:0]         hw_in;
  logic                    busy;
  logic [HW_W+NS_LOG2-1:0] res_sum;
  logic [HW_W-1:0]         res_min;
  logic [HW_W-1:0]         res_max;
  logic                    res_valid;
  logic                    res_ready;

  typedef struct {
    int sum;
    int mn;
    int mx;
  } exp_t;

  exp_t            sb[$];
  int              n_checks    = 0;
  int              n_errors    = 0;
  int              cyc         = 0;
  int              last_launch = -1;
  int              n_launch    = 0;
  int              n_capture   = 0;
  int              exp_period  = 9;
  int              exp_gap     = 3;
  bit              ramp        = 1'b0;
  logic [HW_W-1:0] hw_const    = '0;

  tdc_meas_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_gap   (cfg_gap),
    .launch    (launch),
    .capture   (capture),
    .hw_in     (hw_in),
    .busy      (busy),
    .res_sum   (res_sum),
    .res_min   (res_min),
    .res_max   (res_max),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task monitor_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy) begin
        last_launch = -1;
        n_launch    = 0;
        n_capture   = 0;
      end
      if (launch) begin
        check("launch_capture_overlap", capture, 0);
        if (last_launch >= 0) check("launch_period", cyc - last_launch, exp_period);
        last_launch = cyc;
        n_launch++;
        hw_in = ramp ? HW_W'(n_launch - 1) : hw_const;
      end
      if (capture) begin
        check("capture_after_launch", cyc - last_launch, exp_gap + 1);
        n_capture++;
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_sum", res_sum, e.sum);
          check("res_min", res_min, e.mn);
          check("res_max", res_max, e.mx);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int g, input int period);
    exp_gap    = g;
    exp_period = period;
    @(posedge clk);
    #1;
    start   = 1'b1;
    cfg_gap = GAP_W'(g);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!res_valid && (k < budget)) begin
      tick();
      k++;
    end
    check({name, "_valid_seen"}, res_valid, 1);
  endtask

  task automatic wait_result(input string name, input int budget);
    wait_valid(name, budget);
    tick();
    check({name, "_idle_after"}, busy, 0);
    check({name, "_launches"}, n_launch, 16);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_gap   = '0;
    res_ready = 1'b1;
    hw_in     = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    tick();
    check("rst_launch", launch, 0);
    check("rst_capture", capture, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_min", res_min, 0);
    check("rst_max", res_max, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // gap=3, constant 40: period 9
    ramp = 1'b0;
    hw_const = 7'd40;
    sb.push_back('{640, 40, 40});
    do_start(3, 9);
    wait_result("const40", 400);

    // gap=0, ramp 0..15: period 6
    ramp = 1'b1;
    sb.push_back('{120, 0, 15});
    do_start(0, 6);
    wait_result("ramp", 300);

    // Back-pressure in DONE, then handshake together with a start
    ramp = 1'b0;
    hw_const = 7'd7;
    res_ready = 1'b0;
    sb.push_back('{112, 7, 7});
    do_start(1, 7);
    wait_valid("hold", 300);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_sum", res_sum, 112);
      check("hold_min", res_min, 7);
      check("hold_launch", launch, 0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick();
    check("hold_idle_after", busy, 0);
    check("hold_valid_after", res_valid, 0);
    for (int i = 0; i < 5; i++) tick();
    check("hold_start_ignored", n_launch, 16);
    check("hold_still_idle", busy, 0);

    // Abort during the 5th sample's SYNC
    hw_const = 7'd10;
    do_start(2, 8);
    for (int k = 0; (k < 200) && (n_capture < 5); k++) tick();
    check("abort_reached_capture5", n_capture, 5);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_sum_kept", res_sum, 112);
    check("abort_min_kept", res_min, 7);
    check("abort_max_kept", res_max, 7);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_relaunch", n_launch, 5);

    // Asynchronous reset mid-GAP
    hw_const = 7'd20;
    do_start(3, 9);
    for (int k = 0; (k < 50) && (n_launch < 1); k++) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_launch", launch, 0);
    check("mrst_capture", capture, 0);
    check("mrst_busy", busy, 0);
    check("mrst_valid", res_valid, 0);
    check("mrst_sum", res_sum, 0);
    check("mrst_min", res_min, 0);
    check("mrst_max", res_max, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mrst_no_launch", launch, 0);
    end
    sb.push_back('{320, 20, 20});
    do_start(3, 9);
    wait_result("after_rst", 400);

    // Restart attempts and cfg_gap changes while busy
    hw_const = 7'd5;
    sb.push_back('{80, 5, 5});
    do_start(1, 7);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      start   = ((i % 5) == 0);
      cfg_gap = 4'd6;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result("busy_start", 300);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
